// File: rtl/slc3_mem_arbiter.sv
// Round-robin arbiter/sequencer sharing the SLC-3 single-port memory between CPU and loader.
// Optional loader exclusive lock enabled by defining ARB_LDR_LOCK_EN.
module slc3_mem_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ack,
`ifdef ARB_LDR_LOCK_EN
  input  logic              ldr_lock,
`endif
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_ldr
);

  localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             lat_we;
  logic             last_ldr;
  logic             cpu_elig;
  logic             lock_deny;
  logic             pick_ldr;
  logic             any_req;

`ifdef ARB_LDR_LOCK_EN
  assign cpu_elig = cpu_req & ~ldr_lock;
`else
  assign cpu_elig = cpu_req;
`endif

  // A CPU request masked by the lock must not disturb the round-robin history.
  assign lock_deny = cpu_req & ~cpu_elig;
  assign any_req   = cpu_elig | ldr_req;
  assign pick_ldr  = ldr_req & (~cpu_elig | ~last_ldr);

  assign mem_we = mem_ce & lat_we;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= StIdle;
      cnt       <= '0;
      lat_we    <= 1'b0;
      last_ldr  <= 1'b1;
      grant_ldr <= 1'b0;
      mem_ce    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      ldr_ack   <= 1'b0;
      cpu_rdata <= '0;
      ldr_rdata <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (any_req) begin
            grant_ldr <= pick_ldr;
            if (!lock_deny) begin
              last_ldr <= pick_ldr;
            end
            if (pick_ldr) begin
              lat_we    <= ldr_we;
              mem_addr  <= ldr_addr;
              mem_wdata <= ldr_wdata;
              cnt       <= ldr_we ? CNT_W'(1) : CNT_W'(RD_LAT);
            end else begin
              lat_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              cnt       <= cpu_we ? CNT_W'(1) : CNT_W'(RD_LAT);
            end
            mem_ce <= 1'b1;
            state  <= StBusy;
          end
        end
        StBusy: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            mem_ce <= 1'b0;
            state  <= StDone;
            if (grant_ldr) begin
              ldr_ack <= 1'b1;
              if (!lat_we) begin
                ldr_rdata <= mem_rdata;
              end
            end else begin
              cpu_ack <= 1'b1;
              if (!lat_we) begin
                cpu_rdata <= mem_rdata;
              end
            end
          end
        end
        StDone: begin
          cpu_ack <= 1'b0;
          ldr_ack <= 1'b0;
          state   <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// Directed self-checking bench for slc3_mem_arbiter with a small behavioural memory.
// Lock scenario is exercised only when ARB_LDR_LOCK_EN is defined.
module tb_slc3_mem_arbiter;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned RD_LAT = 2;

  logic              Clk;
  logic              Reset;
  logic              cpu_req, cpu_we, cpu_ack;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              ldr_req, ldr_we, ldr_ack;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata, ldr_rdata;
`ifdef ARB_LDR_LOCK_EN
  logic              ldr_lock;
`endif
  logic              mem_ce, mem_we, grant_ldr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  logic [DATA_W-1:0] mem [0:255];
  logic              pre_en;
  logic [7:0]        pre_addr;
  logic [DATA_W-1:0] pre_data;

  int n_checks;
  int n_errors;

  int cpu_n, ldr_n, cpu_first, ldr_first, cpu_last, ldr_last;
  logic [DATA_W-1:0] cpu_seen, ldr_seen;
  logic              gnt_at_ldr_ack;

  slc3_mem_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .ldr_req   (ldr_req),
    .ldr_we    (ldr_we),
    .ldr_addr  (ldr_addr),
    .ldr_wdata (ldr_wdata),
    .ldr_rdata (ldr_rdata),
    .ldr_ack   (ldr_ack),
`ifdef ARB_LDR_LOCK_EN
    .ldr_lock  (ldr_lock),
`endif
    .mem_ce    (mem_ce),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .grant_ldr (grant_ldr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge Clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (mem_ce && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Run n cycles, tallying acks; optionally drop a port's req once its ack is seen.
  task automatic run(input int n, input bit drop);
    cpu_n = 0; ldr_n = 0; cpu_first = 0; ldr_first = 0; cpu_last = 0; ldr_last = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (cpu_ack) begin
        cpu_n++;
        if (cpu_first == 0) cpu_first = i;
        cpu_last = i;
        cpu_seen = cpu_rdata;
        if (drop) cpu_req = 1'b0;
      end
      if (ldr_ack) begin
        ldr_n++;
        if (ldr_first == 0) ldr_first = i;
        ldr_last = i;
        ldr_seen = ldr_rdata;
        gnt_at_ldr_ack = grant_ldr;
        if (drop) ldr_req = 1'b0;
      end
    end
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    Reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
`ifdef ARB_LDR_LOCK_EN
    ldr_lock = 1'b0;
`endif
    pre_en = 1'b1; pre_addr = 8'h03; pre_data = 16'h1234;
    tick();
    pre_en = 1'b0;
    tick();

    check_eq("rst_mem_ce", mem_ce, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_acks", {cpu_ack, ldr_ack}, 0);
    check_eq("rst_rdata", {cpu_rdata, ldr_rdata}, 0);
    check_eq("rst_grant_ldr", grant_ldr, 0);
    Reset = 1'b0;
    tick();

    // CPU read of 0x0003
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0003;
    tick();
    check_eq("rd_e0_ce", mem_ce, 1);
    check_eq("rd_e0_we", mem_we, 0);
    check_eq("rd_e0_addr", mem_addr, 16'h0003);
    check_eq("rd_e0_ack", cpu_ack, 0);
    tick();
    check_eq("rd_e1_ce", mem_ce, 1);
    check_eq("rd_e1_ack", cpu_ack, 0);
    tick();
    check_eq("rd_e2_ce", mem_ce, 0);
    check_eq("rd_e2_ack", cpu_ack, 1);
    check_eq("rd_e2_rdata", cpu_rdata, 16'h1234);
    check_eq("rd_e2_grant", grant_ldr, 0);
    cpu_req = 0;
    tick();
    check_eq("rd_e3_ack", cpu_ack, 0);

    // Loader write 0xBEEF to 0x0005
    ldr_req = 1; ldr_we = 1; ldr_addr = 16'h0005; ldr_wdata = 16'hBEEF;
    tick();
    check_eq("wr_e0_ce", mem_ce, 1);
    check_eq("wr_e0_we", mem_we, 1);
    check_eq("wr_e0_addr", mem_addr, 16'h0005);
    check_eq("wr_e0_wdata", mem_wdata, 16'hBEEF);
    check_eq("wr_e0_grant", grant_ldr, 1);
    tick();
    check_eq("wr_e1_we", mem_we, 0);
    check_eq("wr_e1_ack", ldr_ack, 1);
    check_eq("wr_e1_cpu_ack", cpu_ack, 0);
    ldr_req = 0;
    tick();
    check_eq("wr_e2_ack", ldr_ack, 0);

    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0005;
    run(6, 1);
    check_eq("rd5_acks", cpu_n, 1);
    check_eq("rd5_lat", cpu_first, 3);
    check_eq("rd5_data", cpu_seen, 16'hBEEF);

    // Tie after reset: CPU first, loader RD_LAT+2 later; twice
    pulse_reset();
    for (int r = 0; r < 2; r++) begin
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0003;
      ldr_req = 1; ldr_we = 0; ldr_addr = 16'h0005;
      run(10, 1);
      check_eq("tie_cpu_ack_cyc", cpu_first, 3);
      check_eq("tie_ldr_ack_cyc", ldr_first, 7);
      check_eq("tie_cpu_data", cpu_seen, 16'h1234);
      check_eq("tie_ldr_data", ldr_seen, 16'hBEEF);
      check_eq("tie_grant_ldr", gnt_at_ldr_ack, 1);
    end

    // Reset pulse in the middle of a CPU read
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0003;
    tick();
    tick();
    check_eq("abort_busy_ce", mem_ce, 1);
    #2 Reset = 1'b1;
    #1;
    check_eq("abort_ce", mem_ce, 0);
    check_eq("abort_ack", cpu_ack, 0);
    check_eq("abort_addr", mem_addr, 0);
    cpu_req = 0;
    #2 Reset = 1'b0;
    run(8, 1);
    check_eq("abort_no_ack", cpu_n + ldr_n, 0);
    cpu_req = 1; cpu_addr = 16'h0005;
    run(6, 1);
    check_eq("post_abort_acks", cpu_n, 1);
    check_eq("post_abort_lat", cpu_first, 3);
    check_eq("post_abort_data", cpu_seen, 16'hBEEF);

    // Request held after ack repeats the transaction
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0003;
    run(7, 0);
    check_eq("hold_rd_acks", cpu_n, 2);
    check_eq("hold_rd_second", cpu_last, 3 + RD_LAT + 2);
    cpu_req = 0;
    run(4, 0);
    check_eq("hold_rd_none_after", cpu_n, 0);

    ldr_req = 1; ldr_we = 1; ldr_addr = 16'h0008; ldr_wdata = 16'h5A5A;
    run(5, 0);
    check_eq("hold_wr_acks", ldr_n, 2);
    check_eq("hold_wr_second", ldr_last, 5);
    ldr_req = 0;
    run(4, 0);
    check_eq("hold_wr_none_after", ldr_n, 0);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0008;
    run(6, 1);
    check_eq("hold_wr_readback", cpu_seen, 16'h5A5A);

`ifdef ARB_LDR_LOCK_EN
    // Lock: only loader served; after unlock the CPU wins the next tie
    begin
      int lcpu, lldr, first_after;
      bit unlocked;
      pulse_reset();
      lcpu = 0; lldr = 0; first_after = 0; unlocked = 0;
      ldr_lock = 1;
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0003;
      ldr_req = 1; ldr_we = 0; ldr_addr = 16'h0005;
      for (int i = 0; i < 60 && first_after == 0; i++) begin
        tick();
        if (unlocked && (cpu_ack || ldr_ack)) first_after = cpu_ack ? 1 : 2;
        if (!unlocked) begin
          if (cpu_ack) lcpu++;
          if (ldr_ack) lldr++;
          if (lldr == 3) begin
            ldr_lock = 0;
            unlocked = 1;
          end
        end
      end
      check_eq("lock_cpu_acks", lcpu, 0);
      check_eq("lock_ldr_acks", lldr, 3);
      check_eq("unlock_cpu_first", first_after, 1);
      cpu_req = 0; ldr_req = 0;
      run(8, 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/slc3_mem_arbiter.md
# slc3_mem_arbiter

Two-port arbiter and sequencer for the SLC-3 single-port on-chip memory. It shares memory between the LC-3 CPU core's MAR/MDR access port and the program loader / debug port. It serialises their requests, drives the memory control strobes for a fixed read latency, and returns data with a one-cycle acknowledge. It sits between `slc3` and the memory block inside the SLC-3 top level.

## Interface
- `ADDR_W`, 16, address width.
- `DATA_W`, 16, data width.
- `RD_LAT`, 2, memory read latency in cycles (≥1). Writes always take 1 cycle.

- `Clk`  in  1  system clock; all state changes on its rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `cpu_req`  in  1  CPU access request; held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  CPU address (MAR).
- `cpu_wdata`  in  DATA_W  CPU write data (MDR).
- `cpu_rdata`  out  DATA_W  CPU read data; valid while `cpu_ack`=1.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_rdata`, `ldr_ack`: same widths, directions and rules as the CPU port.
- `ldr_lock`  in  1  loader exclusive lock. Present only under `ARB_LDR_LOCK_EN`.
- `mem_ce`  out  1  memory chip enable.
- `mem_we`  out  1  memory write enable; asserted only together with `mem_ce`.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; valid at the final cycle of a read.
- `grant_ldr`  out  1  1 while the loader owns the current or most recent transaction.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE
  - Samples requests at each edge.
  - Only one requesting: that requester is granted.
  - Both requesting: round-robin. The grant goes to the requester not granted last.
  - Last-grant register resets to loader, so the CPU wins the first tie.
- On grant:
  - The requester's `we`, `addr` and `wdata` are latched into internal registers.
  - Counter loads `RD_LAT` for a read, 1 for a write.
  - State → BUSY.
- BUSY
  - `mem_ce`=1; `mem_we` = latched `we`.
  - `mem_addr` and `mem_wdata` come from the latched registers and stay stable for the whole transaction.
  - Counter decrements each edge.
  - On the edge where the counter equals 1:
    - for a read, capture `mem_rdata` into the rdata register;
    - state → DONE.
- DONE
  - `mem_ce`=0.
  - Granted port's `ack`=1 for exactly one cycle; its `rdata` = captured value.
  - Next edge → IDLE unconditionally. Requests are not sampled in DONE.
- Requester rules
  - Drop `req`, or change `addr`/`we`/`wdata`, only after seeing `ack`.
  - A `req` still high in the cycle after `ack` is a new request.
- Ungranted port
  - `ack`=0; its `rdata` holds its last value.
  - Its request waits in IDLE with no loss.

## Timing
- Reset values:
  - state IDLE, counter 0;
  - `mem_ce`/`mem_we`=0; `mem_addr`/`mem_wdata`=0;
  - both `ack`=0, both `rdata`=0;
  - `grant_ldr`=0, last-grant = loader.
- Read sampled at edge E0: `mem_ce` high from E0 to E0+RD_LAT, ack high from E0+RD_LAT to E0+RD_LAT+1.
- Write sampled at edge E0: `mem_ce`/`mem_we` high from E0 to E0+1, ack high from E0+1 to E0+2.
- Back-to-back throughput: one read per RD_LAT+2 cycles, one write per 3 cycles.
- Reset asserted mid-BUSY or mid-DONE:
  - outputs return to reset values immediately (asynchronous);
  - the in-flight access is aborted and no ack is issued;
  - a write may or may not have landed in memory.
- All outputs are registered except `mem_we`, which is decoded as `mem_ce` AND latched `we`.

## Configuration
- `ARB_LDR_LOCK_EN` defined:
  - `ldr_lock` port exists.
  - While `ldr_lock`=1 in IDLE, `cpu_req` is ignored and only the loader is granted.
  - A CPU transaction already in BUSY or DONE completes normally.
  - Last-grant is not updated by lock-forced denials.
- Not defined: no `ldr_lock` port; pure round-robin.

## Test plan
- CPU read, RD_LAT=2, memory[0x0003]=0x1234, `cpu_req`=1 addr 0x0003 sampled at E0 → `mem_ce` at E0..E2, `cpu_ack`=1 in cycle E2..E3 with `cpu_rdata`=0x1234.
- Loader write addr 0x0005 data 0xBEEF → `mem_we`=1 for one cycle; `ldr_ack` at E1; a later CPU read of 0x0005 returns 0xBEEF.
- Both request reads at E0 after reset → CPU acked first; loader granted at the next IDLE, `grant_ldr`=1, `ldr_ack` RD_LAT+2 cycles after `cpu_ack`. Repeat the tie → CPU first again (alternation).
- Reset pulse in the middle of BUSY of a CPU read → `mem_ce`=0 and `cpu_ack`=0 immediately; no ack ever issued; next request is served normally.
- With `ARB_LDR_LOCK_EN`, `ldr_lock`=1 and both requesting continuously → only `ldr_ack` pulses. Drop the lock → CPU is granted at the next IDLE.
- Requester holds `req` high after `ack` → a second identical transaction is performed; `ack` pulses exactly twice.
